// File: rtl/bp_fe_cache_req_arbiter.sv
// Arbitrates the FE cache-engine miss port between demand and prefetch requesters and
// routes engine response strobes back to the owner of each in-flight request.
module bp_fe_cache_req_arbiter
  #(parameter int req_width_p      = 1,
    parameter int metadata_width_p = 1,
    parameter int outstanding_p    = 4,
    parameter int starve_limit_p   = 8)
  (input  logic                        clk_i,
   input  logic                        reset_i,

   input  logic [req_width_p-1:0]      demand_req_i,
   input  logic                        demand_req_v_i,
   output logic                        demand_req_yumi_o,
   input  logic [metadata_width_p-1:0] demand_metadata_i,
   input  logic                        demand_metadata_v_i,

   input  logic [req_width_p-1:0]      prefetch_req_i,
   input  logic                        prefetch_req_v_i,
   output logic                        prefetch_req_yumi_o,
   input  logic [metadata_width_p-1:0] prefetch_metadata_i,
   input  logic                        prefetch_metadata_v_i,

   output logic [req_width_p-1:0]      cache_req_o,
   output logic                        cache_req_v_o,
   input  logic                        cache_req_yumi_i,
   input  logic                        cache_req_lock_i,
   output logic [metadata_width_p-1:0] cache_req_metadata_o,
   output logic                        cache_req_metadata_v_o,
   input  logic                        cache_req_critical_i,
   input  logic                        cache_req_last_i,
   input  logic                        cache_req_credits_full_i,

   output logic                        demand_critical_o,
   output logic                        demand_last_o,
   output logic                        prefetch_critical_o,
   output logic                        prefetch_last_o);

  localparam int ptr_w_lp    = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w_lp    = ptr_w_lp + 1;
  localparam int starve_w_lp = (starve_limit_p > 1) ? $clog2(starve_limit_p) : 1;
  localparam logic [cnt_w_lp-1:0]    fifo_depth_lp = cnt_w_lp'(outstanding_p);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p - 1);

  typedef enum logic [1:0] {e_ready, e_lock_demand, e_lock_prefetch} state_e;
  typedef enum logic {e_owner_demand = 1'b0, e_owner_prefetch = 1'b1} owner_e;

  // Handshake: a request transfers on a cycle where cache_req_v_o and cache_req_yumi_i are
  // both high; the matching <x>_req_yumi_o fires that same cycle and nothing is held here.

  state_e state_r, state_n;
  owner_e grant_owner, last_grant_r, head_owner;
  logic   grant_v, accept, push, pop;
  logic   demand_elig, prefetch_elig, starve_force;
  logic   fifo_full, fifo_empty;

  owner_e                 owner_mem_r [outstanding_p];
  logic [ptr_w_lp-1:0]    wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]    fifo_cnt_r;
  logic [starve_w_lp-1:0] starve_cnt_r;

  assign fifo_full     = (fifo_cnt_r == fifo_depth_lp);
  assign fifo_empty    = (fifo_cnt_r == '0);
  assign head_owner    = owner_mem_r[rd_ptr_r];
  assign demand_elig   = demand_req_v_i & ~fifo_full;
  assign prefetch_elig = prefetch_req_v_i & ~fifo_full & ~cache_req_credits_full_i;
  assign starve_force  = (starve_cnt_r == starve_max_lp);

  // A lock state only restricts the grant while the engine still asserts lock; once lock
  // drops the normal priority applies in the same cycle.
  always_comb begin
    grant_v     = 1'b0;
    grant_owner = e_owner_demand;
    state_n     = state_r;

    if (state_r == e_lock_demand && cache_req_lock_i) begin
      grant_v     = demand_elig;
      grant_owner = e_owner_demand;
    end else if (state_r == e_lock_prefetch && cache_req_lock_i) begin
      grant_v     = prefetch_elig;
      grant_owner = e_owner_prefetch;
    end else if (prefetch_elig && (starve_force || !demand_elig)) begin
      grant_v     = 1'b1;
      grant_owner = e_owner_prefetch;
    end else if (demand_elig) begin
      grant_v     = 1'b1;
      grant_owner = e_owner_demand;
    end

    if (grant_v && cache_req_yumi_i && cache_req_lock_i)
      state_n = (grant_owner == e_owner_prefetch) ? e_lock_prefetch : e_lock_demand;
    else if (!cache_req_lock_i)
      state_n = e_ready;
  end

  assign accept = grant_v & cache_req_yumi_i;
  assign push   = accept;
  assign pop    = cache_req_last_i & ~fifo_empty;

  assign cache_req_o         = (grant_owner == e_owner_prefetch) ? prefetch_req_i : demand_req_i;
  assign cache_req_v_o       = grant_v;
  assign demand_req_yumi_o   = accept & (grant_owner == e_owner_demand);
  assign prefetch_req_yumi_o = accept & (grant_owner == e_owner_prefetch);

  assign cache_req_metadata_o   = (last_grant_r == e_owner_prefetch) ? prefetch_metadata_i
                                                                     : demand_metadata_i;
  assign cache_req_metadata_v_o = (last_grant_r == e_owner_prefetch) ? prefetch_metadata_v_i
                                                                     : demand_metadata_v_i;

  // Strobes with nothing in flight are suppressed rather than routed to a stale owner.
  assign demand_critical_o   = cache_req_critical_i & ~fifo_empty & (head_owner == e_owner_demand);
  assign demand_last_o       = cache_req_last_i     & ~fifo_empty & (head_owner == e_owner_demand);
  assign prefetch_critical_o = cache_req_critical_i & ~fifo_empty & (head_owner == e_owner_prefetch);
  assign prefetch_last_o     = cache_req_last_i     & ~fifo_empty & (head_owner == e_owner_prefetch);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_ready;
      last_grant_r <= e_owner_demand;
    end else begin
      state_r <= state_n;
      if (accept)
        last_grant_r <= grant_owner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push) begin
        owner_mem_r[wr_ptr_r] <= grant_owner;
        wr_ptr_r              <= wr_ptr_r + ptr_w_lp'(1);
      end
      if (pop)
        rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      fifo_cnt_r <= fifo_cnt_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || !prefetch_req_v_i || prefetch_req_yumi_o)
      starve_cnt_r <= '0;
    else if (!starve_force)
      starve_cnt_r <= starve_cnt_r + starve_w_lp'(1);
  end

  a_metadata_owner: assert property (@(posedge clk_i) disable iff (reset_i)
    (last_grant_r == e_owner_demand) ? !prefetch_metadata_v_i : !demand_metadata_v_i);

  a_strobe_nonempty: assert property (@(posedge clk_i) disable iff (reset_i)
    (cache_req_critical_i | cache_req_last_i) |-> !fifo_empty);

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Bench for bp_fe_cache_req_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against a queue-based owner model.
module tb_bp_fe_cache_req_arbiter;
  localparam int req_w  = 8;
  localparam int meta_w = 4;
  localparam int depth  = 4;
  localparam int starve = 8;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [req_w-1:0]  demand_req_i, prefetch_req_i, cache_req_o;
  logic              demand_req_v_i, prefetch_req_v_i;
  logic              demand_req_yumi_o, prefetch_req_yumi_o;
  logic [meta_w-1:0] demand_metadata_i, prefetch_metadata_i, cache_req_metadata_o;
  logic              demand_metadata_v_i, prefetch_metadata_v_i, cache_req_metadata_v_o;
  logic              cache_req_v_o, cache_req_yumi_i, cache_req_lock_i;
  logic              cache_req_critical_i, cache_req_last_i, cache_req_credits_full_i;
  logic              demand_critical_o, demand_last_o, prefetch_critical_o, prefetch_last_o;

  int checks = 0;
  int errors = 0;

  bp_fe_cache_req_arbiter #(
    .req_width_p(req_w), .metadata_width_p(meta_w),
    .outstanding_p(depth), .starve_limit_p(starve)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .demand_req_i(demand_req_i), .demand_req_v_i(demand_req_v_i),
    .demand_req_yumi_o(demand_req_yumi_o),
    .demand_metadata_i(demand_metadata_i), .demand_metadata_v_i(demand_metadata_v_i),
    .prefetch_req_i(prefetch_req_i), .prefetch_req_v_i(prefetch_req_v_i),
    .prefetch_req_yumi_o(prefetch_req_yumi_o),
    .prefetch_metadata_i(prefetch_metadata_i), .prefetch_metadata_v_i(prefetch_metadata_v_i),
    .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
    .cache_req_yumi_i(cache_req_yumi_i), .cache_req_lock_i(cache_req_lock_i),
    .cache_req_metadata_o(cache_req_metadata_o), .cache_req_metadata_v_o(cache_req_metadata_v_o),
    .cache_req_critical_i(cache_req_critical_i), .cache_req_last_i(cache_req_last_i),
    .cache_req_credits_full_i(cache_req_credits_full_i),
    .demand_critical_o(demand_critical_o), .demand_last_o(demand_last_o),
    .prefetch_critical_o(prefetch_critical_o), .prefetch_last_o(prefetch_last_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic dv, pv, yumi, lock, crit, last, cfull;
    logic v, pf, dy, py, dc, dl, pc, pl;
  } vec_t;
  vec_t vecs [15];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic dv, pv, yumi, lock, crit, last, cfull);
    demand_req_v_i           = dv;
    prefetch_req_v_i         = pv;
    cache_req_yumi_i         = yumi;
    cache_req_lock_i         = lock;
    cache_req_critical_i     = crit;
    cache_req_last_i         = last;
    cache_req_credits_full_i = cfull;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, pf, dy, py, dc, dl, pc, pl);
    logic [req_w-1:0] exp_req;
    exp_req = pf ? prefetch_req_i : demand_req_i;
    check({tag, ".v"}, cache_req_v_o, v);
    if (v) check({tag, ".req"}, cache_req_o, exp_req);
    check({tag, ".demand_yumi"}, demand_req_yumi_o, dy);
    check({tag, ".prefetch_yumi"}, prefetch_req_yumi_o, py);
    check({tag, ".demand_critical"}, demand_critical_o, dc);
    check({tag, ".demand_last"}, demand_last_o, dl);
    check({tag, ".prefetch_critical"}, prefetch_critical_o, pc);
    check({tag, ".prefetch_last"}, prefetch_last_o, pl);
  endtask

  // reference model state: owner scoreboard queue, lock holder, starvation count
  logic [0:0] exp_q [$];
  int   m_lock_to, m_starve;
  logic m_last;
  logic r_dv, r_pv, r_yumi, r_lock, r_crit, r_last, r_cfull, r_dmv, r_pmv;
  logic g_v, g_pf, acc, has, head, full, d_ok, p_ok;
  logic [meta_w-1:0] r_dm, r_pm;

  initial begin
    //            dv pv yu lk cr la cf | v  pf dy py dc dl pc pl
    vecs[0]  = '{0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1, 1, 0, 0};
    vecs[8]  = '{1, 1, 1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 1, 1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 1};

    reset_i = 1'b1;
    demand_req_i = 8'h11;
    prefetch_req_i = 8'h22;
    demand_metadata_i = 4'h5;
    prefetch_metadata_i = 4'ha;
    demand_metadata_v_i = 1'b1;
    prefetch_metadata_v_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    reset_i = 1'b0;

    // reset state: metadata follows demand, nothing granted or strobed
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset.meta_v", cache_req_metadata_v_o, 1'b1);
    check("reset.meta", cache_req_metadata_o, 4'h5);
    demand_metadata_v_i = 1'b0;
    tick();

    // credits, ordering of responses, lock behaviour
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].dv, vecs[i].pv, vecs[i].yumi, vecs[i].lock,
            vecs[i].crit, vecs[i].last, vecs[i].cfull);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].pf, vecs[i].dy, vecs[i].py,
                vecs[i].dc, vecs[i].dl, vecs[i].pc, vecs[i].pl);
      tick();
    end

    // starvation: 7 demand grants, then prefetch forced, then demand again
    for (int i = 0; i <= 8; i++) begin
      drive(1, 1, 1, 0, 0, i > 0, 0);
      #1;
      check_all($sformatf("starve%0d", i), 1, i == 7, i != 7, i == 7,
                0, (i >= 1 && i <= 7), 0, i == 8);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    check_all("starve_drain", 0, 0, 0, 0, 0, 1, 0, 0);
    tick();

    // owner FIFO full: no grant, including on a same-cycle pop
    for (int i = 0; i < depth; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0);
      #1;
      check_all($sformatf("fill%0d", i), 1, 0, 1, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 0, 0, 0, 0);
    #1;
    check_all("full", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 1, 0);
    #1;
    check_all("full_pop", 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0);
    #1;
    check_all("after_pop", 1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < depth; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      #1;
      check_all($sformatf("drain%0d", i), 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
    end

    // reset in the middle of a demand lock with two requests in flight
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 1, 0, 0, 0);
      #1;
      check_all($sformatf("lock_fill%0d", i), 1, 0, 1, 0, 0, 0, 0, 0);
      tick();
    end
    reset_i = 1'b1;
    drive(1, 1, 0, 1, 0, 0, 0);
    tick();
    reset_i = 1'b0;
    drive(0, 1, 1, 1, 0, 0, 0);
    #1;
    check_all("post_reset", 1, 1, 0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    check_all("post_reset_last", 0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    // randomized traffic against the owner model
    reset_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset_i = 1'b0;
    exp_q.delete();
    m_lock_to = -1;
    m_starve  = 0;
    m_last    = 1'b0;
    for (int n = 0; n < 400; n++) begin
      has     = (exp_q.size() != 0);
      r_dv    = ($urandom_range(0, 9) < 6);
      r_pv    = ($urandom_range(0, 9) < 6);
      r_yumi  = ($urandom_range(0, 9) < 7);
      r_lock  = ($urandom_range(0, 9) < 3);
      r_cfull = ($urandom_range(0, 9) < 2);
      r_crit  = has && ($urandom_range(0, 9) < 3);
      r_last  = has && ($urandom_range(0, 9) < 4);
      r_dm    = meta_w'($urandom);
      r_pm    = meta_w'($urandom);
      r_dmv   = !m_last && ($urandom_range(0, 1) == 1);
      r_pmv   = m_last && ($urandom_range(0, 1) == 1);
      demand_req_i          = req_w'($urandom);
      prefetch_req_i        = req_w'($urandom);
      demand_metadata_i     = r_dm;
      prefetch_metadata_i   = r_pm;
      demand_metadata_v_i   = r_dmv;
      prefetch_metadata_v_i = r_pmv;
      drive(r_dv, r_pv, r_yumi, r_lock, r_crit, r_last, r_cfull);
      #1;

      full = (exp_q.size() == depth);
      d_ok = r_dv && !full;
      p_ok = r_pv && !full && !r_cfull;
      g_v  = 1'b0;
      g_pf = 1'b0;
      if (r_lock && m_lock_to == 0) begin
        g_v = d_ok;
      end else if (r_lock && m_lock_to == 1) begin
        g_v = p_ok; g_pf = 1'b1;
      end else if (p_ok && (m_starve == starve - 1 || !d_ok)) begin
        g_v = 1'b1; g_pf = 1'b1;
      end else if (d_ok) begin
        g_v = 1'b1;
      end
      acc  = g_v && r_yumi;
      head = has ? exp_q[0] : 1'b0;
      check_all($sformatf("rand%0d", n), g_v, g_pf, acc && !g_pf, acc && g_pf,
                r_crit && !head, r_last && !head, r_crit && head, r_last && head);
      check($sformatf("rand%0d.meta_v", n), cache_req_metadata_v_o, m_last ? r_pmv : r_dmv);
      if (m_last ? r_pmv : r_dmv)
        check($sformatf("rand%0d.meta", n), cache_req_metadata_o, m_last ? r_pm : r_dm);

      @(posedge clk_i);
      if (r_last && has) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(g_pf);
        m_last = g_pf;
      end
      if (acc && r_lock) m_lock_to = g_pf ? 1 : 0;
      else if (!r_lock)  m_lock_to = -1;
      if (!r_pv || (acc && g_pf)) m_starve = 0;
      else if (m_starve < starve - 1) m_starve++;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
